// File: rtl/weapon_pkg.sv
// Shared types and constants for the weapon controller: FSM states, wound codes,
// and the widths of the ammo, clip and hit-point fields.
package weapon_pkg;

  localparam int AM_W   = 6;
  localparam int CLIP_W = 2;
  localparam int HP_W   = 7;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COOLDOWN = 2'd1,
    RELOAD   = 2'd2,
    DEAD     = 2'd3
  } state_e;

  localparam logic [1:0] WOUND_NONE  = 2'b00;
  localparam logic [1:0] WOUND_LIGHT = 2'b01;
  localparam logic [1:0] WOUND_HEAVY = 2'b10;
  localparam logic [1:0] WOUND_DEAD  = 2'b11;

  localparam logic [HP_W-1:0]   HEAVY_DMG = HP_W'(20);
  localparam logic [CLIP_W-1:0] CLIP_MAX  = 2'd3;

  // Hit-point subtraction that floors at zero.
  function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] a,
                                              input logic [HP_W-1:0] b);
    return (b >= a) ? '0 : a - b;
  endfunction

endpackage

// File: rtl/weapon_ctrl_down_timer.sv
// Loadable down-counter shared by cooldown and reload; sticks at zero and
// raises a zero flag.
module down_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] value;

  always_ff @(posedge clk) begin
    if (!reset)                       value <= '0;
    else if (load)                    value <= load_val;
    else if (dec && (value != '0))    value <= value - W'(1);
  end

  assign zero = (value == '0);

endmodule

// File: rtl/weapon_ctrl.sv
// Weapon/health controller: firing, cooldown, reloading, pickups and damage.
// Define WEAPON_CTRL_AUTOFIRE_EN for level-triggered automatic fire.
module weapon_ctrl
  import weapon_pkg::*;
#(
  parameter int MAG_SIZE      = 30,
  parameter int CLIP_INIT     = 3,
  parameter int HP_INIT       = 99,
  parameter int FIRE_GAP      = 5_000_000,
  parameter int RELOAD_CYCLES = 100_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              trigger,
  input  logic              reload_req,
  input  logic              hit,
  input  logic [HP_W-1:0]   hit_dmg,
  input  logic              pickup,
  output logic [AM_W-1:0]   am,
  output logic [CLIP_W-1:0] clip,
  output logic [HP_W-1:0]   hp,
  output logic              shoot,
  output logic              dry,
  output logic [1:0]        wound,
  output logic              busy
);

  localparam int TMAX = (FIRE_GAP > RELOAD_CYCLES) ? FIRE_GAP : RELOAD_CYCLES;
  localparam int TW   = $clog2(TMAX);

  localparam logic [AM_W-1:0]   MAG   = AM_W'(MAG_SIZE);
  localparam logic [CLIP_W-1:0] CLIP0 = CLIP_W'(CLIP_INIT);
  localparam logic [HP_W-1:0]   HP0   = HP_W'(HP_INIT);
  localparam logic [TW-1:0]     GAP_LD = TW'(FIRE_GAP - 1);
  localparam logic [TW-1:0]     RLD_LD = TW'(RELOAD_CYCLES - 1);

  state_e            state;
  logic              trig_q;
  logic              fire_evt, ready, idle, tmr_zero, tmr_load, tmr_dec;
  logic              killed, shot, dry_evt, rld_start, rld_done, pickup_ok;
  logic [TW-1:0]     tmr_load_val;
  logic [HP_W-1:0]   hp_hit;
  logic [CLIP_W:0]   clip_sum;
  logic [CLIP_W-1:0] clip_next;

`ifdef WEAPON_CTRL_AUTOFIRE_EN
  assign fire_evt = trigger;
`else
  assign fire_evt = trigger & ~trig_q;
`endif

  // The cycle the cooldown timer expires is treated as IDLE so shots can be
  // exactly FIRE_GAP cycles apart.
  assign idle  = (state == IDLE);
  assign ready = idle || ((state == COOLDOWN) && tmr_zero);

  assign hp_hit    = sat_sub(hp, hit_dmg);
  assign killed    = (state != DEAD) && hit && (hp_hit == '0);
  assign pickup_ok = pickup && (state != DEAD);

  assign shot      = ready && !killed && fire_evt && (am != '0);
  assign dry_evt   = ready && !killed && fire_evt && (am == '0) && (clip == '0);
  assign rld_start = ready && !killed && (clip != '0) &&
                     ( (fire_evt && (am == '0)) ||
                       (!fire_evt && idle && reload_req && (am < MAG)) );
  assign rld_done  = (state == RELOAD) && tmr_zero && !killed;

  assign clip_sum  = {1'b0, clip} - {{CLIP_W{1'b0}}, rld_done}
                                  + {{CLIP_W{1'b0}}, pickup_ok};
  assign clip_next = (clip_sum > {1'b0, CLIP_MAX}) ? CLIP_MAX : clip_sum[CLIP_W-1:0];

  assign tmr_load     = shot || rld_start;
  assign tmr_load_val = shot ? GAP_LD : RLD_LD;
  assign tmr_dec      = (state == COOLDOWN) || (state == RELOAD);

  down_timer #(.W(TW)) u_tmr (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      am     <= MAG;
      clip   <= CLIP0;
      hp     <= HP0;
      wound  <= WOUND_NONE;
      shoot  <= 1'b0;
      dry    <= 1'b0;
      busy   <= 1'b0;
      trig_q <= 1'b1;
    end else begin
      trig_q <= trigger;
      shoot  <= shot;
      dry    <= dry_evt;

      if (state != DEAD) begin
        clip <= clip_next;
        if (hit) begin
          hp <= hp_hit;
          if (hp_hit == '0)           wound <= WOUND_DEAD;
          else if (hit_dmg >= HEAVY_DMG) wound <= WOUND_HEAVY;
          else                        wound <= WOUND_LIGHT;
        end
      end

      if (shot)          am <= am - AM_W'(1);
      else if (rld_done) am <= MAG;

      if (killed) begin
        state <= DEAD;
        busy  <= 1'b0;
      end else if (shot) begin
        state <= COOLDOWN;
        busy  <= 1'b1;
      end else if (rld_start) begin
        state <= RELOAD;
        busy  <= 1'b1;
      end else if (rld_done || ((state == COOLDOWN) && tmr_zero)) begin
        state <= IDLE;
        busy  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_weapon_ctrl.sv
// Directed bench for weapon_ctrl with a shot scoreboard (expected cycle and
// remaining ammo per shoot pulse). Works in both fire-mode builds.
module tb_weapon_ctrl;
  import weapon_pkg::*;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              trigger = 1'b0, reload_req = 1'b0, hit = 1'b0, pickup = 1'b0;
  logic [HP_W-1:0]   hit_dmg = '0;
  logic [AM_W-1:0]   am;
  logic [CLIP_W-1:0] clip;
  logic [HP_W-1:0]   hp;
  logic              shoot, dry, busy;
  logic [1:0]        wound;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int cyc;
    int am;
  } shot_t;

  shot_t sb[$];
  shot_t exp_shot;

  weapon_ctrl #(
    .MAG_SIZE(3), .CLIP_INIT(1), .HP_INIT(50), .FIRE_GAP(4), .RELOAD_CYCLES(8)
  ) dut (
    .clk(clk), .reset(reset), .trigger(trigger), .reload_req(reload_req),
    .hit(hit), .hit_dmg(hit_dmg), .pickup(pickup),
    .am(am), .clip(clip), .hp(hp), .shoot(shoot), .dry(dry),
    .wound(wound), .busy(busy)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One trigger pulse that must fire, then cooldown busy for exactly 4 cycles.
  task automatic fire(input int exp_am);
    trigger = 1'b1;
    sb.push_back('{cyc + 1, exp_am});
    step(1);
    trigger = 1'b0;
    for (int j = 0; j < 4; j++) begin
      chk("busy_cooldown", busy, 1);
      step(1);
    end
    chk("busy_after_cooldown", busy, 0);
  endtask

  always @(negedge clk) begin
    if (reset && shoot) begin
      total++;
      assert (sb.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_shoot observed=shot@%0d expected=none", cyc);
      end
      if (sb.size() != 0) begin
        exp_shot = sb.pop_front();
        chk("shoot_cycle", cyc, exp_shot.cyc);
        chk("shoot_am", am, exp_shot.am);
      end
    end
  end

  initial begin
    // Reset with trigger held: stale trigger history must not fire.
    trigger = 1'b1;
    step(2);
    chk("rst_am", am, 3);
    chk("rst_clip", clip, 1);
    chk("rst_hp", hp, 50);
    chk("rst_wound", wound, 0);
    chk("rst_shoot", shoot, 0);
    chk("rst_dry", dry, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b1;
`ifndef WEAPON_CTRL_AUTOFIRE_EN
    step(3);
    chk("held_trig_after_rst_am", am, 3);
`endif
    trigger = 1'b0;
    step(1);

    // Three shots, 5 cycles apart.
    fire(2);
    fire(1);
    fire(0);
    chk("am_empty", am, 0);

    // Auto reload on trigger with empty magazine.
    trigger = 1'b1;
    step(1);
    trigger = 1'b0;
    for (int j = 0; j < 8; j++) begin
      chk("busy_reload", busy, 1);
      chk("am_during_reload", am, 0);
      step(1);
    end
    chk("reload_am", am, 3);
    chk("reload_clip", clip, 0);
    chk("reload_busy_end", busy, 0);

    // Full magazine: reload_req ignored.
    reload_req = 1'b1;
    step(1);
    reload_req = 1'b0;
    chk("reload_req_ignored_busy", busy, 0);

    // Empty everything, then dry fire.
    fire(2);
    fire(1);
    fire(0);
    trigger = 1'b1;
    step(1);
    trigger = 1'b0;
    chk("dry_pulse", dry, 1);
    chk("dry_busy", busy, 0);
    step(1);
    chk("dry_one_cycle", dry, 0);
    chk("dry_clip", clip, 0);

    // Pickups, saturating at 3.
    pickup = 1'b1;
    step(1);
    pickup = 1'b0;
    chk("pickup_one", clip, 1);
    pickup = 1'b1;
    step(4);
    pickup = 1'b0;
    chk("pickup_sat", clip, 3);

    // Manual reload with pickup on the completion edge: clip nets unchanged.
    reload_req = 1'b1;
    step(1);
    reload_req = 1'b0;
    chk("manual_reload_busy", busy, 1);
    step(7);
    pickup = 1'b1;
    step(1);
    pickup = 1'b0;
    chk("reload_pickup_am", am, 3);
    chk("reload_pickup_clip", clip, 3);
    chk("reload_pickup_busy", busy, 0);

    // Damage.
    hit = 1'b1; hit_dmg = 7'd10;
    step(1);
    hit = 1'b0;
    chk("hit10_hp", hp, 40);
    chk("hit10_wound", wound, 1);
    hit = 1'b1; hit_dmg = 7'd25;
    step(1);
    hit = 1'b0;
    chk("hit25_hp", hp, 15);
    chk("hit25_wound", wound, 2);
    hit = 1'b1; hit_dmg = 7'd30; trigger = 1'b1;
    step(1);
    hit = 1'b0; trigger = 1'b0;
    chk("kill_hp", hp, 0);
    chk("kill_wound", wound, 3);
    chk("kill_shoot", shoot, 0);
    chk("kill_am", am, 3);
    chk("kill_busy", busy, 0);

    // Dead: everything ignored.
    step(1);
    trigger = 1'b1; reload_req = 1'b1; hit = 1'b1; hit_dmg = 7'd5;
    step(6);
    trigger = 1'b0; reload_req = 1'b0; hit = 1'b0;
    step(1);
    chk("dead_am", am, 3);
    chk("dead_hp", hp, 0);
    chk("dead_wound", wound, 3);
    chk("dead_busy", busy, 0);
    chk("dead_dry", dry, 0);

    // Reset out of DEAD, then abort a reload at cycle 4.
    reset = 1'b0;
    step(1);
    reset = 1'b1;
    step(1);
    chk("rst2_hp", hp, 50);
    chk("rst2_wound", wound, 0);
    fire(2);
    reload_req = 1'b1;
    step(1);
    reload_req = 1'b0;
    chk("abort_reload_busy", busy, 1);
    step(3);
    reset = 1'b0;
    step(1);
    reset = 1'b1;
    chk("abort_am", am, 3);
    chk("abort_clip", clip, 1);
    chk("abort_hp", hp, 50);
    chk("abort_busy", busy, 0);
    step(12);
    chk("abort_no_complete_am", am, 3);
    chk("abort_no_complete_clip", clip, 1);

    // Trigger held for 12 cycles.
    trigger = 1'b1;
`ifdef WEAPON_CTRL_AUTOFIRE_EN
    sb.push_back('{cyc + 1, 2});
    sb.push_back('{cyc + 5, 1});
    sb.push_back('{cyc + 9, 0});
`else
    sb.push_back('{cyc + 1, 2});
`endif
    step(12);
    trigger = 1'b0;
    step(6);
`ifdef WEAPON_CTRL_AUTOFIRE_EN
    chk("held_am", am, 0);
`else
    chk("held_am", am, 2);
`endif
    chk("held_busy", busy, 0);

    chk("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
